// File: rtl/ariane_pkg.sv
// Shared core types used by the BTB write path.
// Provides the branch-resolution and BTB-update payloads, control-flow kinds,
// and the default depth of the BTB update queue.
package ariane_pkg;

    localparam int unsigned BTB_UPD_QUEUE_DEPTH = 4;

    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        cf_t         cf_type;
    } bp_resolve_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
    } btb_update_t;

endpackage

// File: rtl/btb_update_queue_pkg.sv
// Local types for the BTB update queue: one queued {pc, target} entry.
package btb_update_queue_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target_address;
    } btb_upd_entry_t;

endpackage

// File: rtl/btb_update_queue.sv
// Coalescing FIFO of resolved JALR mispredicts feeding the frontend BTB.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   flush_i              discard all queued updates
//   debug_mode_i         hold contents: no enqueue, no drain
//   resolved_branch_i    branch resolution from execute
//   wr_ready_i           BTB write port free this cycle
//   btb_update_o         update toward the BTB (head entry)
//   full_o, empty_o      occupancy flags
//   drop_cnt_o           saturating count of updates lost to a full queue
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = ariane_pkg::BTB_UPD_QUEUE_DEPTH,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    debug_mode_i,
    input  ariane_pkg::bp_resolve_t resolved_branch_i,
    input  logic                    wr_ready_i,
    output ariane_pkg::btb_update_t btb_update_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    btb_upd_entry_t         mem_q [DEPTH];
    btb_upd_entry_t         mem_d [DEPTH];
    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DROP_CNT_W-1:0]  drop_q, drop_d;

    logic                   full_c, empty_c;
    logic                   pop_c, cand_c;
    logic                   match_any_c;
    logic [PTR_W-1:0]       match_idx_c;
    logic                   coalesce_c, push_c, drop_c;

    // Candidate classification, CAM match and push/pop/drop decisions
    always_comb begin
        full_c      = (cnt_q == CNT_W'(DEPTH));
        empty_c     = (cnt_q == '0);
        pop_c       = !empty_c && wr_ready_i && !debug_mode_i && !flush_i;
        cand_c      = resolved_branch_i.valid && resolved_branch_i.is_mispredict &&
                      (resolved_branch_i.cf_type == ariane_pkg::JumpR) &&
                      !debug_mode_i && !flush_i;
        match_any_c = 1'b0;
        match_idx_c = '0;
        // Queued PCs are unique, so at most one entry hits
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (mem_q[i].pc[63:1] == resolved_branch_i.pc[63:1])) begin
                match_any_c = 1'b1;
                match_idx_c = PTR_W'(i);
            end
        end
        // A hit on the head that is leaving this cycle must re-allocate,
        // otherwise the newer target would leave with nothing to hold it
        coalesce_c = cand_c && match_any_c && !(pop_c && (match_idx_c == head_q));
        push_c     = cand_c && !coalesce_c && (!full_c || pop_c);
        drop_c     = cand_c && !coalesce_c && full_c && !pop_c;
    end

    // Next-state for storage, pointers and counters
    always_comb begin
        mem_d  = mem_q;
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        if (flush_i) begin
            vld_d  = '0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (coalesce_c) begin
                mem_d[match_idx_c].target_address = resolved_branch_i.target_address;
            end
            if (pop_c) begin
                vld_d[head_q] = 1'b0;
                head_d        = head_q + PTR_W'(1);
            end
            // Pop is applied first so a full queue can reuse the slot it frees
            if (push_c) begin
                mem_d[tail_q].pc             = resolved_branch_i.pc;
                mem_d[tail_q].target_address = resolved_branch_i.target_address;
                vld_d[tail_q]                = 1'b1;
                tail_d                       = tail_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (drop_c && (drop_q != '1)) begin
                drop_d = drop_q + DROP_CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
        end else begin
            mem_q  <= mem_d;
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    // Head entry drives the BTB directly from registers
    always_comb begin
        btb_update_o.valid          = pop_c;
        btb_update_o.pc             = mem_q[head_q].pc;
        btb_update_o.target_address = mem_q[head_q].target_address;
    end

    assign full_o     = full_c;
    assign empty_o    = empty_c;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Randomized and directed bench for btb_update_queue against a queue-based model.
module tb_btb_update_queue;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          dbg;
    bp_resolve_t   rb;
    logic          rdy;
    btb_update_t   upd;
    logic          full;
    logic          empty;
    logic [DW-1:0] drop;

    btb_update_queue #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .debug_mode_i     (dbg),
        .resolved_branch_i(rb),
        .wr_ready_i       (rdy),
        .btb_update_o     (upd),
        .full_o           (full),
        .empty_o          (empty),
        .drop_cnt_o       (drop)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: ordered list of pending {pc, target} plus drop count
    logic [63:0] m_pc[$];
    logic [63:0] m_tgt[$];
    int unsigned m_drop = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs, advance the model
    task automatic step(input logic v, input logic [63:0] pc, input logic [63:0] tgt,
                        input logic misp, input cf_t cf, input logic r, input logic d,
                        input logic fl);
        logic exp_valid;
        logic cand;
        logic merged;
        int   hit;
        @(negedge clk);
        rb.valid          = v;
        rb.pc             = pc;
        rb.target_address = tgt;
        rb.is_mispredict  = misp;
        rb.cf_type        = cf;
        rdy               = r;
        dbg               = d;
        flush             = fl;
        #1;
        exp_valid = (m_pc.size() != 0) && r && !d && !fl;
        check("valid", 64'(upd.valid), 64'(exp_valid));
        check("full",  64'(full),  64'(m_pc.size() == DEPTH));
        check("empty", 64'(empty), 64'(m_pc.size() == 0));
        check("drop",  64'(drop),  64'(m_drop));
        if (m_pc.size() != 0) begin
            check("head_pc",  upd.pc,             m_pc[0]);
            check("head_tgt", upd.target_address, m_tgt[0]);
        end
        if (fl) begin
            m_pc.delete();
            m_tgt.delete();
        end else if (!d) begin
            cand   = v && misp && (cf == JumpR);
            merged = 1'b0;
            hit    = -1;
            foreach (m_pc[i]) begin
                if ((m_pc[i] >> 1) == (pc >> 1)) hit = i;
            end
            if (cand && hit >= 0 && !(hit == 0 && exp_valid)) begin
                m_tgt[hit] = tgt;
                merged     = 1'b1;
            end
            if (exp_valid) begin
                void'(m_pc.pop_front());
                void'(m_tgt.pop_front());
            end
            if (cand && !merged) begin
                if (m_pc.size() < DEPTH) begin
                    m_pc.push_back(pc);
                    m_tgt.push_back(tgt);
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
    endtask

    task automatic idle(input logic r, input logic d);
        step(1'b0, 64'h0, 64'h0, 1'b0, NoCF, r, d, 1'b0);
    endtask

    task automatic jalr(input logic [63:0] pc, input logic [63:0] tgt, input logic r);
        step(1'b1, pc, tgt, 1'b1, JumpR, r, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rb    = '0;
        rdy   = 1'b0;
        dbg   = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc.delete();
        m_tgt.delete();
        m_drop = 0;
        #1;
        check("rst_valid", 64'(upd.valid), 64'h0);
        check("rst_pc",    upd.pc,             64'h0);
        check("rst_tgt",   upd.target_address, 64'h0);
        check("rst_empty", 64'(empty), 64'h1);
        check("rst_full",  64'(full),  64'h0);
        check("rst_drop",  64'(drop),  64'h0);
    endtask

    logic [63:0] exp_order [4];

    initial begin
        rst_n = 1'b1;
        rb    = '0;
        rdy   = 1'b0;
        dbg   = 1'b0;
        flush = 1'b0;
        do_reset();

        // Single mispredict appears one cycle later, then queue empties
        jalr(64'h8000_0010, 64'h8000_2000, 1'b1);
        check("t1_no_bypass", 64'(upd.valid), 64'h0);
        idle(1'b1, 1'b0);
        check("t1_valid", 64'(upd.valid), 64'h1);
        check("t1_pc",  upd.pc,             64'h8000_0010);
        check("t1_tgt", upd.target_address, 64'h8000_2000);
        idle(1'b1, 1'b0);
        check("t1_empty", 64'(empty), 64'h1);

        // Same-PC updates coalesce into one entry carrying the newest target
        jalr(64'h100, 64'h200, 1'b0);
        jalr(64'h100, 64'h300, 1'b0);
        idle(1'b0, 1'b0);
        check("t2_one_entry", 64'(m_pc.size()), 64'h1);
        idle(1'b1, 1'b0);
        check("t2_pc",  upd.pc,             64'h100);
        check("t2_tgt", upd.target_address, 64'h300);
        idle(1'b1, 1'b0);
        check("t2_empty_after", 64'(empty), 64'h1);

        // Overflow: five distinct with no drain
        for (int i = 0; i < 5; i++) jalr(64'h1000 + 64'(16 * i), 64'hA000 + 64'(i), 1'b0);
        idle(1'b0, 1'b0);
        check("t3_full", 64'(full), 64'h1);
        check("t3_drop", 64'(drop), 64'h1);

        // Full with simultaneous pop and distinct push: no drop, new entry last
        jalr(64'h5000, 64'h5555, 1'b1);
        check("t4_pop_pc", upd.pc, 64'h1000);
        exp_order = '{64'h1010, 64'h1020, 64'h1030, 64'h5000};
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 1'b0);
            check("t4_order", upd.pc, exp_order[i]);
        end
        check("t4_drop", 64'(drop), 64'h1);
        idle(1'b1, 1'b0);

        // Flush with a same-cycle candidate
        for (int i = 0; i < 3; i++) jalr(64'h2000 + 64'(16 * i), 64'hB000, 1'b0);
        step(1'b1, 64'h3000, 64'hC000, 1'b1, JumpR, 1'b1, 1'b0, 1'b1);
        check("t5_flush_noout", 64'(upd.valid), 64'h0);
        idle(1'b1, 1'b0);
        check("t5_empty", 64'(empty), 64'h1);
        check("t5_drop_kept", 64'(drop), 64'h1);

        // Reset with queued entries and a nonzero drop count
        for (int i = 0; i < 3; i++) jalr(64'h2000 + 64'(16 * i), 64'hB000, 1'b0);
        do_reset();

        // Non-candidates ignored; debug mode holds contents
        step(1'b1, 64'h600, 64'h700, 1'b1, Branch, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h610, 64'h710, 1'b0, JumpR,  1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        check("t6_ignored", 64'(empty), 64'h1);
        jalr(64'h620, 64'h720, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 64'h630, 64'h730, 1'b1, JumpR, 1'b1, 1'b1, 1'b0);
            check("t6_dbg_hold", 64'(upd.valid), 64'h0);
        end
        idle(1'b1, 1'b0);
        check("t6_dbg_exit_pc", upd.pc, 64'h620);
        idle(1'b1, 1'b0);
        check("t6_dbg_drop_cand", 64'(empty), 64'h1);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) jalr(64'h9000 + 64'(4 * i), 64'h1, 1'b0);
        idle(1'b0, 1'b0);
        check("sat_drop", 64'(drop), 64'hFF);
        do_reset();

        // Random traffic with varying drain pressure
        for (int ph = 0; ph < 6; ph++) begin
            for (int n = 0; n < 500; n++) begin
                cf_t c;
                logic [63:0] pc;
                c  = ($urandom % 4 == 0) ? Branch : JumpR;
                pc = 64'h4000 + 64'(4 * $urandom_range(0, 7)) + 64'($urandom % 2);
                step(($urandom % 4) != 0, pc, {$urandom, $urandom},
                     ($urandom % 5) != 0, c,
                     ($urandom % 6) < (ph + 1),
                     ($urandom % 20) == 0,
                     ($urandom % 60) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
